// File: rtl/id_scoreboard.sv
// -----------------------------------------------------------------------------
// id_scoreboard
//
// Purpose:
//   Per-register latency scoreboard for the decode stage. Every in-flight
//   register write is tracked by a countdown of the cycles left until its
//   result reaches a forwarding bus. Decode is stalled on RAW hazards (a
//   source is still counting) and on WAW hazards (an older write to the same
//   destination would complete at or after the new one). All tracking freezes
//   while the downstream pipeline holds.
//
// Optional feature:
//   SCOREBOARD_STATS_EN - adds saturating 32-bit RAW/WAW stall counters
//   (stat_raw_stalls, stat_waw_stalls) and a synchronous clear (stat_clr).
//
// Ports:
//   cpu_clk_50M     in   core clock, all state updates on the rising edge
//   cpu_rst         in   synchronous active-high reset, clears all tracking
//   issue_valid     in   decode holds a valid instruction
//   issue_rs        in   source 1 register      issue_rs_used in  source 1 read
//   issue_rt        in   source 2 register      issue_rt_used in  source 2 read
//   issue_rfwe      in   instruction writes a register
//   issue_rfwa      in   destination register
//   issue_lat       in   cycles until the result is forwardable
//   pipe_hold       in   downstream stall, in-flight pipeline frozen
//   id_stop         out  decode must stall this cycle
//   issue_fire      out  instruction accepted this cycle
//   rs_pending      out  remaining count of issue_rs
//   rt_pending      out  remaining count of issue_rt
//   busy_vec        out  bit r set while register r has a write in flight
//   stat_clr        in   (stats build only) clear both stall counters
//   stat_raw_stalls out  (stats build only) cycles stalled on RAW
//   stat_waw_stalls out  (stats build only) cycles stalled on WAW
// -----------------------------------------------------------------------------
module id_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 4,
  localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
`ifdef SCOREBOARD_STATS_EN
  input  logic             stat_clr,
  output logic [31:0]      stat_raw_stalls,
  output logic [31:0]      stat_waw_stalls,
`endif
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs,
  input  logic             issue_rs_used,
  input  logic [AW-1:0]    issue_rt,
  input  logic             issue_rt_used,
  input  logic             issue_rfwe,
  input  logic [AW-1:0]    issue_rfwa,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             pipe_hold,
  output logic             id_stop,
  output logic             issue_fire,
  output logic [LAT_W-1:0] rs_pending,
  output logic [LAT_W-1:0] rt_pending,
  output logic [NREG-1:0]  busy_vec
);

  localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);

  // Current countdown of every register, register 0 tied to zero.
  logic [LAT_W-1:0] w_cnt [NREG];

  logic [LAT_W-1:0] w_eff_lat;
  logic             w_wr_tracked;
  logic             w_raw;
  logic             w_waw;
  logic             w_stop;
  logic             w_fire;

  // Latencies above MAX_LAT are clamped; a latency of 0 means nothing is
  // tracked for this write.
  assign w_eff_lat    = (issue_lat > MAX_LAT_C) ? MAX_LAT_C : issue_lat;
  assign w_wr_tracked = issue_rfwe && (issue_rfwa != '0) && (w_eff_lat != '0);

  assign w_raw = (issue_rs_used && (issue_rs != '0) && (w_cnt[issue_rs] != '0)) ||
                 (issue_rt_used && (issue_rt != '0) && (w_cnt[issue_rt] != '0));

  // An older write still counting at or above the new latency would land
  // after the younger one and overwrite the newer value.
  assign w_waw = w_wr_tracked && (w_cnt[issue_rfwa] >= w_eff_lat);

  assign w_stop = issue_valid && (w_raw || w_waw || pipe_hold);
  assign w_fire = issue_valid && !w_stop;

  assign id_stop    = w_stop;
  assign issue_fire = w_fire;
  assign rs_pending = w_cnt[issue_rs];
  assign rt_pending = w_cnt[issue_rt];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_cnt[gi]    = '0;
        assign busy_vec[gi] = 1'b0;
      end else begin : g_track
        logic [LAT_W-1:0] r_cnt;
        logic             w_load;

        assign w_load = w_fire && w_wr_tracked && (issue_rfwa == AW'(gi));

        always_ff @(posedge cpu_clk_50M) begin
          if (cpu_rst) begin
            r_cnt <= '0;
          end else if (!pipe_hold) begin
            // A new issue overrides the decrement of an older write.
            if (w_load) begin
              r_cnt <= w_eff_lat;
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end

        assign w_cnt[gi]    = r_cnt;
        assign busy_vec[gi] = (r_cnt != '0);
      end
    end
  endgenerate

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] r_raw_stalls;
  logic [31:0] r_waw_stalls;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || stat_clr) begin
      r_raw_stalls <= '0;
      r_waw_stalls <= '0;
    end else if (issue_valid && !pipe_hold) begin
      if (w_raw && (r_raw_stalls != 32'hFFFF_FFFF)) begin
        r_raw_stalls <= r_raw_stalls + 32'd1;
      end
      if (w_waw && (r_waw_stalls != 32'hFFFF_FFFF)) begin
        r_waw_stalls <= r_waw_stalls + 32'd1;
      end
    end
  end

  assign stat_raw_stalls = r_raw_stalls;
  assign stat_waw_stalls = r_waw_stalls;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_id_scoreboard
//
// Directed bench for id_scoreboard. Each step drives one cycle of decode
// inputs, pushes the expected outputs for that cycle onto a scoreboard queue,
// then pops and compares them against the DUT mid-cycle.
// -----------------------------------------------------------------------------
module tb_id_scoreboard;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = 3;

  logic             cpu_clk_50M = 1'b0;
  logic             cpu_rst;
  logic             issue_valid;
  logic [AW-1:0]    issue_rs;
  logic             issue_rs_used;
  logic [AW-1:0]    issue_rt;
  logic             issue_rt_used;
  logic             issue_rfwe;
  logic [AW-1:0]    issue_rfwa;
  logic [LAT_W-1:0] issue_lat;
  logic             pipe_hold;
  logic             id_stop;
  logic             issue_fire;
  logic [LAT_W-1:0] rs_pending;
  logic [LAT_W-1:0] rt_pending;
  logic [NREG-1:0]  busy_vec;
`ifdef SCOREBOARD_STATS_EN
  logic             stat_clr;
  logic [31:0]      stat_raw_stalls;
  logic [31:0]      stat_waw_stalls;
`endif

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  id_scoreboard #(
    .NREG    (NREG),
    .AW      (AW),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .cpu_clk_50M     (cpu_clk_50M),
    .cpu_rst         (cpu_rst),
`ifdef SCOREBOARD_STATS_EN
    .stat_clr        (stat_clr),
    .stat_raw_stalls (stat_raw_stalls),
    .stat_waw_stalls (stat_waw_stalls),
`endif
    .issue_valid     (issue_valid),
    .issue_rs        (issue_rs),
    .issue_rs_used   (issue_rs_used),
    .issue_rt        (issue_rt),
    .issue_rt_used   (issue_rt_used),
    .issue_rfwe      (issue_rfwe),
    .issue_rfwa      (issue_rfwa),
    .issue_lat       (issue_lat),
    .pipe_hold       (pipe_hold),
    .id_stop         (id_stop),
    .issue_fire      (issue_fire),
    .rs_pending      (rs_pending),
    .rt_pending      (rt_pending),
    .busy_vec        (busy_vec)
  );

  typedef struct {
    string            tag;
    logic             stop;
    logic             fire;
    logic [LAT_W-1:0] rsp;
    logic [LAT_W-1:0] rtp;
    logic [NREG-1:0]  busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [NREG-1:0] bit_of(input int r);
    logic [NREG-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs, record its expectation, check it mid-cycle.
  task automatic step(
    input string            tag,
    input logic             v,
    input logic [AW-1:0]    rs,
    input logic             rsu,
    input logic [AW-1:0]    rt,
    input logic             rtu,
    input logic             we,
    input logic [AW-1:0]    wa,
    input logic [LAT_W-1:0] lat,
    input logic             hold,
    input logic             e_stop,
    input logic             e_fire,
    input logic [LAT_W-1:0] e_rsp,
    input logic [LAT_W-1:0] e_rtp,
    input logic [NREG-1:0]  e_busy
  );
    exp_t e;
    issue_valid   = v;
    issue_rs      = rs;
    issue_rs_used = rsu;
    issue_rt      = rt;
    issue_rt_used = rtu;
    issue_rfwe    = we;
    issue_rfwa    = wa;
    issue_lat     = lat;
    pipe_hold     = hold;
    e.tag  = tag;
    e.stop = e_stop;
    e.fire = e_fire;
    e.rsp  = e_rsp;
    e.rtp  = e_rtp;
    e.busy = e_busy;
    sb_q.push_back(e);

    @(negedge cpu_clk_50M);
    e = sb_q.pop_front();
    $display("cycle %-20s stop=%0b fire=%0b rsp=%0d rtp=%0d busy=%08h",
             e.tag, id_stop, issue_fire, rs_pending, rt_pending, busy_vec);
    n_vec++;
    assert (id_stop === e.stop) else begin
      n_err++;
      $error("FAIL %s id_stop: observed %0b expected %0b", e.tag, id_stop, e.stop);
    end
    n_vec++;
    assert (issue_fire === e.fire) else begin
      n_err++;
      $error("FAIL %s issue_fire: observed %0b expected %0b", e.tag, issue_fire, e.fire);
    end
    n_vec++;
    assert (rs_pending === e.rsp) else begin
      n_err++;
      $error("FAIL %s rs_pending: observed %0d expected %0d", e.tag, rs_pending, e.rsp);
    end
    n_vec++;
    assert (rt_pending === e.rtp) else begin
      n_err++;
      $error("FAIL %s rt_pending: observed %0d expected %0d", e.tag, rt_pending, e.rtp);
    end
    n_vec++;
    assert (busy_vec === e.busy) else begin
      n_err++;
      $error("FAIL %s busy_vec: observed %08h expected %08h", e.tag, busy_vec, e.busy);
    end
    @(posedge cpu_clk_50M);
    #1;
  endtask

  initial begin
    cpu_rst       = 1'b1;
    issue_valid   = 1'b0;
    issue_rs      = '0;
    issue_rs_used = 1'b0;
    issue_rt      = '0;
    issue_rt_used = 1'b0;
    issue_rfwe    = 1'b0;
    issue_rfwa    = '0;
    issue_lat     = '0;
    pipe_hold     = 1'b0;
`ifdef SCOREBOARD_STATS_EN
    stat_clr      = 1'b0;
`endif
    repeat (2) @(posedge cpu_clk_50M);
    #1;
    cpu_rst = 1'b0;

    // Reset state with no valid instruction.
    step("rst_idle", 0, 0,0, 0,0, 0,0,0, 0,  0,0,0,0,'0);

    // 1: ALU write r5 (lat 1), reader of r5 on source 2.
    step("t1_alu_r5",  1, 0,0, 0,0, 1,5,1, 0,  0,1,0,0,'0);
    step("t1_rd_r5_a", 1, 0,0, 5,1, 0,0,0, 0,  1,0,0,1,bit_of(5));
    step("t1_rd_r5_b", 1, 0,0, 5,1, 0,0,0, 0,  0,1,0,0,'0);

    // 2: load write r8 (lat 2), reader of r8 on source 1.
    step("t2_ld_r8",   1, 0,0, 0,0, 1,8,2, 0,  0,1,0,0,'0);
    step("t2_rd_r8_a", 1, 8,1, 0,0, 0,0,0, 0,  1,0,2,0,bit_of(8));
    step("t2_rd_r8_b", 1, 8,1, 0,0, 0,0,0, 0,  1,0,1,0,bit_of(8));
    step("t2_rd_r8_c", 1, 8,1, 0,0, 0,0,0, 0,  0,1,0,0,'0);

    // 3: MUL r9 (lat 4) then ALU r9 (lat 1): WAW while the old count >= 1.
    // rs=9 unused, so rs_pending exposes the raw count without a RAW stall.
    step("t3_mul_r9",  1, 0,0, 0,0, 1,9,4, 0,  0,1,0,0,'0);
    for (int k = 4; k >= 1; k--)
      step("t3_waw_r9", 1, 9,0, 0,0, 1,9,1, 0,  1,0,LAT_W'(k),0,bit_of(9));
    step("t3_alu_r9",  1, 9,0, 0,0, 1,9,1, 0,  0,1,0,0,'0);
    step("t3_rd_r9_a", 1, 9,1, 0,0, 0,0,0, 0,  1,0,1,0,bit_of(9));
    step("t3_rd_r9_b", 1, 9,1, 0,0, 0,0,0, 0,  0,1,0,0,'0);
    // Older write shorter than the new one: no WAW stall, count reloads.
    step("t3_alu_r11", 1, 0,0, 0,0, 1,11,1, 0, 0,1,0,0,'0);
    step("t3_mul_r11", 1, 0,0, 11,0, 1,11,4, 0, 0,1,0,1,bit_of(11));
    for (int k = 4; k >= 1; k--)
      step("t3_r11_drain", 0, 11,0, 0,0, 0,0,0, 0, 0,0,LAT_W'(k),0,bit_of(11));
    step("t3_r11_free", 0, 11,0, 0,0, 0,0,0, 0, 0,0,0,0,'0);

    // 4: load r3 (lat 2), three hold cycles freeze the count, then release.
    // The held write to r6 must never be tracked.
    step("t4_ld_r3",   1, 0,0, 0,0, 1,3,2, 0,  0,1,0,0,'0);
    for (int k = 0; k < 3; k++)
      step("t4_hold",  1, 3,1, 0,0, 1,6,1, 1,  1,0,2,0,bit_of(3));
    step("t4_rd_r3_a", 1, 3,1, 0,0, 0,0,0, 0,  1,0,2,0,bit_of(3));
    step("t4_rd_r3_b", 1, 3,1, 0,0, 0,0,0, 0,  1,0,1,0,bit_of(3));
    step("t4_rd_r3_c", 1, 3,1, 0,0, 0,0,0, 0,  0,1,0,0,'0);
    step("t4_hold_idle", 0, 0,0, 0,0, 0,0,0, 1, 0,0,0,0,'0);

    // 5: r0 never tracked; issue_lat 7 clamps to 4 on r4.
    step("t5_wr_r0",   1, 0,0, 0,0, 1,0,4, 0,  0,1,0,0,'0);
    step("t5_rd_r0_wr_r4", 1, 0,1, 0,1, 1,4,7, 0, 0,1,0,0,'0);
    for (int k = 4; k >= 1; k--)
      step("t5_r4_clamp", 0, 4,0, 0,0, 0,0,0, 0, 0,0,LAT_W'(k),0,bit_of(4));
    step("t5_r4_free", 0, 4,0, 0,0, 0,0,0, 0,  0,0,0,0,'0);
    // Read-and-write of a free register issues against the old count.
    step("t5_self_r12", 1, 12,1, 12,1, 1,12,2, 0, 0,1,0,0,'0);
    step("t5_r12_a",   0, 12,0, 0,0, 0,0,0, 0,  0,0,2,0,bit_of(12));
    step("t5_r12_b",   0, 12,0, 0,0, 0,0,0, 0,  0,0,1,0,bit_of(12));
    step("t5_r12_c",   0, 12,0, 0,0, 0,0,0, 0,  0,0,0,0,'0);
    // Latency 0 is not a tracked write.
    step("t5_lat0_r13", 1, 0,0, 0,0, 1,13,0, 0, 0,1,0,0,'0);
    step("t5_lat0_chk", 0, 13,0, 0,0, 0,0,0, 0, 0,0,0,0,'0);

    // 6: MUL r10, then reset on the next edge while another write fires.
    step("t6_mul_r10", 1, 0,0, 0,0, 1,10,4, 0, 0,1,0,0,'0);
    cpu_rst = 1'b1;
    step("t6_rst_issue", 1, 0,0, 0,0, 1,14,3, 0, 0,1,0,0,bit_of(10));
    cpu_rst = 1'b0;
    step("t6_rd_r10",  1, 10,1, 14,1, 0,0,0, 0, 0,1,0,0,'0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
